// File: rtl/pipe_reg_elastic_pkg.sv
// Shared types and helpers for elastic pipeline registers.
package pipe_reg_elastic_pkg;

  // Hazard-unit control bundle; unpacked onto stall_i/flush_i at each stage.
  typedef struct packed {
    logic stall;
    logic flush;
  } elastic_ctrl_t;

  // Modulo-depth pointer increment: wraps explicitly from depth-1 to 0 so
  // non-power-of-2 depths never rely on binary overflow.
  function automatic int unsigned ptr_incr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still carries a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH-entry in-order buffer with valid/ready
// handshake, global stall/flush and occupancy output. in_ready_o depends
// combinationally only on stall_i, never on out_ready_i.
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WIDTH-1:0]          in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_p0 [DEPTH];
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [CNT_W-1:0] count_p0;

  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;

  // ---- stage p0 outputs: handshake and head presentation ----
  assign not_empty   = (count_p0 != '0);
  assign not_full    = (count_p0 != FULL_CNT);
  assign in_ready_o  = not_full & ~stall_i;
  assign out_valid_o = not_empty & ~stall_i;
  assign out_data_o  = not_empty ? mem_p0[rd_ptr_p0] : '0;
  assign count_o     = count_p0;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // Next-state for pointers and occupancy; flush empties the buffer and
  // voids any handshake that happened in the same cycle.
  always_comb begin
    rd_ptr_nxt = rd_ptr_p0;
    wr_ptr_nxt = wr_ptr_p0;
    count_nxt  = count_p0;
    if (flush_i) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = PTR_W'(ptr_incr(32'(wr_ptr_p0), DEPTH));
      end
      if (pop) begin
        rd_ptr_nxt = PTR_W'(ptr_incr(32'(rd_ptr_p0), DEPTH));
      end
      count_nxt = count_p0 + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register; reset drops every entry and overrides flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      rd_ptr_p0 <= rd_ptr_nxt;
      wr_ptr_p0 <= wr_ptr_nxt;
      count_p0  <= count_nxt;
    end
  end

  // Payload storage; contents are only meaningful under count_p0, so no reset.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_p0[wr_ptr_p0] <= in_data_i;
    end
  end

`ifndef SYNTHESIS
  // Occupancy and pointers must stay inside the buffer range.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (count_p0 <= FULL_CNT);
      assert (32'(rd_ptr_p0) < DEPTH);
      assert (32'(wr_ptr_p0) < DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Testbench for pipe_reg_elastic: three instances (DEPTH 2, 3, 1; WIDTH 8)
// driven by directed vectors, with per-instance scoreboard monitors.
module tb_pipe_reg_elastic;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk_i = ~clk_i;

  // DEPTH=2 instance
  logic       stall_a = 0, flush_a = 0, iv_a = 0, or_a = 0;
  logic [7:0] id_a = 0;
  logic       ir_a, ov_a;
  logic [7:0] od_a;
  logic [1:0] cnt_a;

  // DEPTH=3 instance
  logic       stall_b = 0, flush_b = 0, iv_b = 0, or_b = 0;
  logic [7:0] id_b = 0;
  logic       ir_b, ov_b;
  logic [7:0] od_b;
  logic [1:0] cnt_b;

  // DEPTH=1 instance
  logic       stall_c = 0, flush_c = 0, iv_c = 0, or_c = 0;
  logic [7:0] id_c = 0;
  logic       ir_c, ov_c;
  logic [7:0] od_c;
  logic [0:0] cnt_c;

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(2)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_n), .stall_i(stall_a), .flush_i(flush_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .in_data_i(id_a),
    .out_valid_o(ov_a), .out_ready_i(or_a), .out_data_o(od_a), .count_o(cnt_a));

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_n), .stall_i(stall_b), .flush_i(flush_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .in_data_i(id_b),
    .out_valid_o(ov_b), .out_ready_i(or_b), .out_data_o(od_b), .count_o(cnt_b));

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(1)) dut_c (
    .clk_i(clk_i), .rst_ni(rst_n), .stall_i(stall_c), .flush_i(flush_c),
    .in_valid_i(iv_c), .in_ready_o(ir_c), .in_data_i(id_c),
    .out_valid_o(ov_c), .out_ready_i(or_c), .out_data_o(od_c), .count_o(cnt_c));

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 20 && (qa.size() + qb.size() + qc.size()) != 0; n++) cyc();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);
  endtask

  // Scoreboard monitors: every accepted output must match the queue head.
  always @(negedge clk_i) begin
    if (rst_n && !flush_a && ov_a && or_a) begin
      if (qa.size() == 0) chk("a_unexpected_out", {24'h0, od_a}, 32'hFFFF_FFFF);
      else chk("a_out_data", {24'h0, od_a}, {24'h0, qa.pop_front()});
    end
  end

  always @(negedge clk_i) begin
    if (rst_n && !flush_b && ov_b && or_b) begin
      if (qb.size() == 0) chk("b_unexpected_out", {24'h0, od_b}, 32'hFFFF_FFFF);
      else chk("b_out_data", {24'h0, od_b}, {24'h0, qb.pop_front()});
    end
  end

  always @(negedge clk_i) begin
    if (rst_n && !flush_c && ov_c && or_c) begin
      if (qc.size() == 0) chk("c_unexpected_out", {24'h0, od_c}, 32'hFFFF_FFFF);
      else chk("c_out_data", {24'h0, od_c}, {24'h0, qc.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_in_ready", ir_a, 1);
    chk("rst_count_b", cnt_b, 0);
    chk("rst_count_c", cnt_c, 0);
    cyc();

    // Streaming, DEPTH=2
    qa = {8'h11, 8'h22, 8'h33, 8'h44};
    or_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iv_a = (i < 4);
      id_a = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : (i == 2) ? 8'h33 : 8'h44;
      @(negedge clk_i);
      chk("stream_out_valid", ov_a, (i >= 1 && i <= 4));
      if (i < 4) chk("stream_in_ready", ir_a, 1);
      chk("stream_count_le1", (cnt_a <= 2'd1), 1);
      cyc();
    end
    iv_a = 1'b0;
    drain_all();

    // Backpressure, full and wrap, DEPTH=3
    qb = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    or_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv_b = 1'b1;
      id_b = 8'(8'hA1 + i);
      @(negedge clk_i);
      chk("full_fill_ready", ir_b, 1);
      cyc();
    end
    id_b = 8'hA4;
    @(negedge clk_i);
    chk("full_count", cnt_b, 3);
    chk("full_in_ready", ir_b, 0);
    chk("full_out_valid", ov_b, 1);
    chk("full_head", od_b, 8'hA1);
    cyc();
    @(negedge clk_i);
    chk("full_a4_rejected", cnt_b, 3);
    cyc();
    or_b = 1'b1;
    for (int j = 0; j < 4; j++) begin
      int n;
      n = 0;
      iv_b = 1'b1;
      id_b = 8'(8'hA4 + j);
      @(negedge clk_i);
      while (!ir_b && n < 8) begin
        cyc();
        @(negedge clk_i);
        n++;
      end
      chk("wrap_push_accepted", ir_b, 1);
      cyc();
    end
    iv_b = 1'b0;
    drain_all();
    or_b = 1'b0;

    // Flush with simultaneous push/pop, DEPTH=2
    qa = {8'h55, 8'h88};
    or_a = 1'b1;
    iv_a = 1'b1;
    id_a = 8'h55;
    cyc();
    id_a = 8'h66;
    @(negedge clk_i);
    chk("flush_pre_head", od_a, 8'h55);
    cyc();
    id_a = 8'h77;
    flush_a = 1'b1;
    @(negedge clk_i);
    chk("flush_in_ready_reported", ir_a, 1);
    chk("flush_out_valid_reported", ov_a, 1);
    cyc();
    flush_a = 1'b0;
    iv_a = 1'b0;
    @(negedge clk_i);
    chk("flush_count", cnt_a, 0);
    chk("flush_out_valid", ov_a, 0);
    cyc();
    iv_a = 1'b1;
    id_a = 8'h88;
    cyc();
    iv_a = 1'b0;
    @(negedge clk_i);
    chk("post_flush_valid", ov_a, 1);
    cyc();
    drain_all();

    // Stall, DEPTH=2
    qa = {8'h99};
    or_a = 1'b0;
    iv_a = 1'b1;
    id_a = 8'h99;
    cyc();
    iv_a = 1'b0;
    stall_a = 1'b1;
    or_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_out_valid", ov_a, 0);
      chk("stall_in_ready", ir_a, 0);
      chk("stall_count", cnt_a, 1);
      chk("stall_head_held", od_a, 8'h99);
      cyc();
    end
    stall_a = 1'b0;
    @(negedge clk_i);
    chk("unstall_valid", ov_a, 1);
    chk("unstall_data", od_a, 8'h99);
    cyc();
    drain_all();
    or_a = 1'b0;

    // DEPTH=1 throughput: one acceptance every second cycle
    qc = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    or_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv_c = 1'b1;
      id_c = 8'(8'hC0 + i / 2);
      @(negedge clk_i);
      chk("d1_ready_alternates", ir_c, (i % 2 == 0));
      cyc();
    end

    // Reset mid-stream with one entry held
    id_c = 8'hC4;
    @(negedge clk_i);
    chk("d1_push_c4", ir_c, 1);
    cyc();
    iv_c = 1'b0;
    or_c = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_i);
    chk("d1_held_count", cnt_c, 1);
    chk("d1_held_valid", ov_c, 1);
    cyc();
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("midrst_count", cnt_c, 0);
    chk("midrst_out_valid", ov_c, 0);
    chk("midrst_out_data", od_c, 0);
    chk("midrst_in_ready", ir_c, 1);
    cyc();
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
